// File: rtl/stream_out.sv
// Output stage of the filter pipeline: tags pixels with end-of-row/frame from
// the configured geometry and buffers them in a FWFT FIFO for a valid/ready sink.
module stream_out #(
   parameter int IMG_WIDTH   = 8,
   parameter int MEM_AWIDTH  = 16,
   parameter int FIFO_AWIDTH = 4,
   parameter int FIFO_DEPTH  = 1 << FIFO_AWIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [MEM_AWIDTH-1:0]  cfg_cols,
   input  logic [MEM_AWIDTH-1:0]  cfg_rows,
   input  logic                   cfg_set,
   input  logic [IMG_WIDTH-1:0]   up_data,
   input  logic                   up_val,
   output logic [IMG_WIDTH-1:0]   dn_data,
   output logic                   dn_eol,
   output logic                   dn_eof,
   output logic                   dn_val,
   input  logic                   dn_rdy,
   output logic                   overflow,
   output logic [FIFO_AWIDTH:0]   fifo_count
);

   localparam int EW = IMG_WIDTH + 2;
   localparam logic [MEM_AWIDTH-1:0]  GEO_ONE  = 1;
   localparam logic [FIFO_AWIDTH-1:0] PTR_ONE  = 1;
   localparam logic [FIFO_AWIDTH:0]   CNT_ONE  = 1;
   localparam logic [FIFO_AWIDTH:0]   CNT_FULL = FIFO_DEPTH[FIFO_AWIDTH:0];

   logic [MEM_AWIDTH-1:0]  cols_m1;
   logic [MEM_AWIDTH-1:0]  rows_m1;
   logic [MEM_AWIDTH-1:0]  col_cnt;
   logic [MEM_AWIDTH-1:0]  row_cnt;
   logic [MEM_AWIDTH-1:0]  col_eff;
   logic [MEM_AWIDTH-1:0]  row_eff;
   logic                   cfg_set_q;
   logic                   tag_eol;
   logic                   tag_eof;

   logic [EW-1:0]          mem [FIFO_DEPTH];
   logic [FIFO_AWIDTH-1:0] wr_ptr;
   logic [FIFO_AWIDTH-1:0] rd_ptr;
   logic [FIFO_AWIDTH:0]   count;
   logic                   full;
   logic                   push;
   logic                   pop;
   logic                   drop;
   logic [EW-1:0]          head;

   // In the cycle after cfg_set the counters read as zero so that cycle's pixel lands at col 0, row 0.
   always_comb begin
      col_eff = cfg_set_q ? '0 : col_cnt;
      row_eff = cfg_set_q ? '0 : row_cnt;
      tag_eol = (col_eff == cols_m1);
      tag_eof = tag_eol && (row_eff == rows_m1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cols_m1   <= '1;
         rows_m1   <= '1;
         cfg_set_q <= 1'b0;
      end else begin
         cfg_set_q <= cfg_set;
         if (cfg_set) begin
            cols_m1 <= cfg_cols - GEO_ONE;
            rows_m1 <= cfg_rows - GEO_ONE;
         end
      end
   end

   // Tags advance on every valid pixel, dropped or not, so geometry never slips.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end else if (up_val) begin
         col_cnt <= tag_eol ? '0 : col_eff + GEO_ONE;
         row_cnt <= tag_eol ? (tag_eof ? '0 : row_eff + GEO_ONE) : row_eff;
      end else if (cfg_set_q) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end
   end

   always_comb begin
      full = (count == CNT_FULL);
      pop  = dn_val && dn_rdy;
      push = up_val && (!full || pop);
      drop = up_val && full && !pop;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {tag_eof, tag_eol, up_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push && !pop) begin
            count <= count + CNT_ONE;
         end else if (pop && !push) begin
            count <= count - CNT_ONE;
         end
      end
   end

   // A drop in the clearing cycle is fresh news, so it wins over the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (cfg_set_q) begin
         overflow <= 1'b0;
      end
   end

   always_comb begin
      head       = mem[rd_ptr];
      dn_data    = head[IMG_WIDTH-1:0];
      dn_eol     = head[IMG_WIDTH];
      dn_eof     = head[IMG_WIDTH+1];
      dn_val     = (count != '0);
      fifo_count = count;
   end

endmodule

// File: tb/tb_stream_out.sv
// Bench for stream_out: a cycle model of tagging and FIFO occupancy feeds a
// scoreboard queue; table vectors and hand sequences cover the corner cases.
module tb_stream_out;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cfg_cols = '0;
   logic [15:0] cfg_rows = '0;
   logic        cfg_set = 1'b0;
   logic [7:0]  up_data = '0;
   logic        up_val = 1'b0;
   logic [7:0]  dn_data;
   logic        dn_eol;
   logic        dn_eof;
   logic        dn_val;
   logic        dn_rdy = 1'b0;
   logic        overflow;
   logic [4:0]  fifo_count;

   stream_out dut (
      .clk(clk), .rst(rst), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows), .cfg_set(cfg_set),
      .up_data(up_data), .up_val(up_val), .dn_data(dn_data), .dn_eol(dn_eol),
      .dn_eof(dn_eof), .dn_val(dn_val), .dn_rdy(dn_rdy), .overflow(overflow),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       eol;
      logic       eof;
   } vec_t;

   vec_t        tbl[16];
   logic [9:0]  q[$];
   logic [9:0]  out_log[$];
   logic [15:0] m_col, m_row, m_cm1, m_rm1;
   logic        m_clr, m_ovf;
   logic        primed = 1'b0;
   int          nvec = 0;
   int          nmis = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One clock: drive inputs after the falling edge, check, advance the model at the rising edge.
   task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic rd,
                      input logic s, input logic [15:0] c, input logic [15:0] rw);
      logic        pop, full, push, drop, eol, eof;
      logic [15:0] ec, er;
      logic [9:0]  hd;
      rst = r; up_val = v; up_data = d; dn_rdy = rd; cfg_set = s; cfg_cols = c; cfg_rows = rw;
      #1;
      hd = {dn_eof, dn_eol, dn_data};
      if (primed) begin
         chk("dn_val", 32'(dn_val), 32'(q.size() != 0));
         if (q.size() != 0) chk("head", 32'(hd), 32'(q[0]));
      end
      pop  = (q.size() != 0) && rd;
      full = (q.size() == 16);
      ec   = m_clr ? 16'd0 : m_col;
      er   = m_clr ? 16'd0 : m_row;
      eol  = (ec == m_cm1);
      eof  = eol && (er == m_rm1);
      push = v && (!full || pop);
      drop = v && full && !pop;
      @(posedge clk);
      if (r) begin
         q.delete();
         m_col = '0; m_row = '0; m_cm1 = '1; m_rm1 = '1; m_clr = 1'b0; m_ovf = 1'b0;
         primed = 1'b1;
      end else begin
         if (pop) begin
            void'(q.pop_front());
            out_log.push_back(hd);
         end
         if (push) q.push_back({eof, eol, d});
         if (drop) m_ovf = 1'b1;
         else if (m_clr) m_ovf = 1'b0;
         if (v) begin
            m_col = eol ? 16'd0 : ec + 16'd1;
            m_row = eol ? (eof ? 16'd0 : er + 16'd1) : er;
         end else if (m_clr) begin
            m_col = '0; m_row = '0;
         end
         if (s) begin
            m_cm1 = c - 16'd1;
            m_rm1 = rw - 16'd1;
         end
         m_clr = s;
      end
      @(negedge clk);
      if (primed) begin
         chk("fifo_count", 32'(fifo_count), 32'(q.size()));
         chk("overflow", 32'(overflow), 32'(m_ovf));
      end
   endtask

   task automatic pixels(input int n, input logic [7:0] base, input logic rd);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, base + 8'(i), rd, 1'b0, 16'd0, 16'd0);
   endtask

   task automatic idle(input int n, input logic rd);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'd0, rd, 1'b0, 16'd0, 16'd0);
   endtask

   task automatic cfg(input logic [15:0] c, input logic [15:0] rw, input logic rd);
      cyc(1'b0, 1'b0, 8'd0, rd, 1'b1, c, rw);
   endtask

   task automatic log_chk(input string nm, input int idx, input logic [9:0] exp);
      chk(nm, (idx < out_log.size()) ? 32'(out_log[idx]) : 32'hdead, 32'(exp));
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         tbl[i].data = 8'(i);
         tbl[i].eol  = ((i % 4) == 3);
         tbl[i].eof  = ((i % 8) == 7);
      end
      m_col = '0; m_row = '0; m_cm1 = '1; m_rm1 = '1; m_clr = 1'b0; m_ovf = 1'b0;
      @(negedge clk);
      cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0);
      cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0);
      chk("reset_dn_val", 32'(dn_val), 32'd0);
      chk("reset_count", 32'(fifo_count), 32'd0);
      chk("reset_overflow", 32'(overflow), 32'd0);

      // 4x2 geometry, two frames streamed straight through
      cfg(16'd4, 16'd2, 1'b1);
      out_log.delete();
      for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, tbl[i].data, 1'b1, 1'b0, 16'd0, 16'd0);
      idle(3, 1'b1);
      chk("t1_count", 32'(out_log.size()), 32'd16);
      for (int i = 0; i < 16; i++) log_chk("t1_out", i, {tbl[i].eof, tbl[i].eol, tbl[i].data});

      // fill to full, drop one, drain
      out_log.delete();
      pixels(16, 8'd100, 1'b0);
      chk("t2_full", 32'(fifo_count), 32'd16);
      chk("t2_no_ovf", 32'(overflow), 32'd0);
      pixels(1, 8'd116, 1'b0);
      chk("t2_ovf", 32'(overflow), 32'd1);
      idle(18, 1'b1);
      chk("t2_drained", 32'(out_log.size()), 32'd16);
      for (int i = 0; i < 16; i++) log_chk("t2_data", i, {tbl[i].eof, tbl[i].eol, 8'(100 + i)});
      pixels(2, 8'd120, 1'b1);
      idle(3, 1'b1);

      // push and pop together while full
      cfg(16'd4, 16'd2, 1'b1);
      pixels(16, 8'd0, 1'b0);
      pixels(20, 8'd16, 1'b1);
      chk("t3_count", 32'(fifo_count), 32'd16);
      chk("t3_ovf", 32'(overflow), 32'd0);
      idle(18, 1'b1);

      // random backpressure
      for (int i = 0; i < 200; i++) cyc(1'b0, 1'b1, 8'(i), 1'($urandom_range(0, 1)), 1'b0, 16'd0, 16'd0);
      idle(18, 1'b1);

      // mid-row reconfig with entries still buffered and overflow set
      cfg(16'd5, 16'd3, 1'b1);
      pixels(17, 8'd0, 1'b0);
      chk("t5_ovf_set", 32'(overflow), 32'd1);
      idle(14, 1'b1);
      chk("t5_left", 32'(fifo_count), 32'd2);
      cfg(16'd3, 16'd2, 1'b0);
      pixels(1, 8'd200, 1'b0);
      chk("t5_ovf_clr", 32'(overflow), 32'd0);
      pixels(2, 8'd201, 1'b0);
      out_log.delete();
      idle(6, 1'b1);
      log_chk("t5_old14", 0, {2'b11, 8'd14});
      log_chk("t5_old15", 1, {2'b00, 8'd15});
      log_chk("t5_col0", 2, {2'b00, 8'd200});
      log_chk("t5_col1", 3, {2'b00, 8'd201});
      log_chk("t5_eol", 4, {2'b01, 8'd202});

      // reset with 5 buffered entries and overflow raised
      pixels(17, 8'd50, 1'b0);
      idle(11, 1'b1);
      chk("t6_pre", 32'(fifo_count), 32'd5);
      cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0);
      chk("t6_dn_val", 32'(dn_val), 32'd0);
      chk("t6_count", 32'(fifo_count), 32'd0);
      chk("t6_ovf", 32'(overflow), 32'd0);
      out_log.delete();
      pixels(4, 8'd77, 1'b1);
      idle(3, 1'b1);
      log_chk("t6_first", 0, {2'b00, 8'd77});
      log_chk("t6_fourth", 3, {2'b00, 8'd80});

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
